// File: rtl/peg_scorer.sv
// peg_scorer: sequential Mastermind grader.
// Scores one latched guess against a latched secret code, one peg per cycle:
// a RED pass for exact matches, then a WHITE pass that pairs each unmatched
// code peg with the lowest-index unused guess peg of the same colour.
// Optional feature macro: PEG_SCORER_WIN_EN adds a registered win flag and lets
// a perfect guess skip the WHITE pass.
module peg_scorer #(
  parameter int unsigned PEGS    = 4,
  parameter int unsigned COLOR_W = 3,
  localparam int unsigned CNT_W  = $clog2(PEGS + 1),
  localparam int unsigned IDX_W  = (PEGS > 2) ? $clog2(PEGS) : 1
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [PEGS*COLOR_W-1:0] code,
  input  logic [PEGS*COLOR_W-1:0] guess,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        red,
  output logic [CNT_W-1:0]        white
`ifdef PEG_SCORER_WIN_EN
  ,
  output logic                    win
`endif
);

  typedef enum logic [1:0] {StIdle, StRed, StWhite, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(PEGS - 1);
  localparam logic [CNT_W-1:0] AllPegs  = CNT_W'(PEGS);

  state_e             state;
  logic [IDX_W-1:0]   idx;
  logic [COLOR_W-1:0] code_q  [PEGS];
  logic [COLOR_W-1:0] guess_q [PEGS];
  logic [PEGS-1:0]    code_used;
  logic [PEGS-1:0]    guess_used;

  logic               red_hit;
  logic               match_found;
  logic [IDX_W-1:0]   match_idx;

  // Exact match of the peg currently under the index.
  always_comb begin
    red_hit = (code_q[idx] == guess_q[idx]);
  end

  // Priority encoder: lowest unused guess peg with the current code peg's colour.
  // Scanning high-to-low lets the lowest index overwrite the others.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int j = PEGS - 1; j >= 0; j--) begin
      if (!guess_used[j] && (guess_q[j] == code_q[idx])) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(j);
      end
    end
  end

`ifdef PEG_SCORER_WIN_EN
  logic [CNT_W-1:0] red_final;

  // Red count including the hit being scored this cycle, used to decide the skip.
  always_comb begin
    red_final = red_hit ? (red + CNT_W'(1)) : red;
  end
`endif

  // Scoring FSM with registered outputs; synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= StIdle;
      idx        <= '0;
      code_used  <= '0;
      guess_used <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      red        <= '0;
      white      <= '0;
      for (int i = 0; i < PEGS; i++) begin
        code_q[i]  <= '0;
        guess_q[i] <= '0;
      end
`ifdef PEG_SCORER_WIN_EN
      win        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            for (int i = 0; i < PEGS; i++) begin
              code_q[i]  <= code[i*COLOR_W +: COLOR_W];
              guess_q[i] <= guess[i*COLOR_W +: COLOR_W];
            end
            code_used  <= '0;
            guess_used <= '0;
            red        <= '0;
            white      <= '0;
            idx        <= '0;
            busy       <= 1'b1;
            state      <= StRed;
`ifdef PEG_SCORER_WIN_EN
            win        <= 1'b0;
`endif
          end
        end

        StRed: begin
          if (red_hit) begin
            red             <= red + CNT_W'(1);
            code_used[idx]  <= 1'b1;
            guess_used[idx] <= 1'b1;
          end
          if (idx == LastIdx) begin
            idx <= '0;
`ifdef PEG_SCORER_WIN_EN
            // A perfect guess leaves nothing for the white pass.
            if (red_final == AllPegs) begin
              state <= StDone;
              done  <= 1'b1;
              win   <= 1'b1;
            end else begin
              state <= StWhite;
            end
`else
            state <= StWhite;
`endif
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        StWhite: begin
          if (!code_used[idx] && match_found) begin
            white                 <= white + CNT_W'(1);
            guess_used[match_idx] <= 1'b1;
            code_used[idx]        <= 1'b1;
          end
          if (idx == LastIdx) begin
            idx   <= '0;
            state <= StDone;
            done  <= 1'b1;
`ifdef PEG_SCORER_WIN_EN
            win   <= (red == AllPegs);
`endif
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        StDone: begin
          // start is ignored here; the next request is taken from IDLE.
          busy  <= 1'b0;
          state <= StIdle;
        end

        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

  // Each peg is consumed at most once, so the total can never exceed PEGS.
  assert property (@(posedge clock) disable iff (!resetn)
    ((CNT_W + 1)'(red) + (CNT_W + 1)'(white)) <= (CNT_W + 1)'(PEGS));

  // done only ever pulses while the block reports busy.
  assert property (@(posedge clock) disable iff (!resetn) done |-> busy);

endmodule

// File: tb/tb_peg_scorer.sv
// tb_peg_scorer: table vectors, randomized guesses against a colour-count
// model, and hand sequences for reset abort, ignored start and held start.
module tb_peg_scorer;
  localparam int PEGS    = 4;
  localparam int COLOR_W = 3;
  localparam int CNT_W   = 3;
  localparam int W       = PEGS * COLOR_W;

  logic             clock  = 1'b0;
  logic             resetn = 1'b0;
  logic             start  = 1'b0;
  logic [W-1:0]     code   = '0;
  logic [W-1:0]     guess  = '0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] red;
  logic [CNT_W-1:0] white;
`ifdef PEG_SCORER_WIN_EN
  logic             win;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  peg_scorer #(.PEGS(PEGS), .COLOR_W(COLOR_W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .code   (code),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .red    (red),
    .white  (white)
`ifdef PEG_SCORER_WIN_EN
    ,
    .win    (win)
`endif
  );

  typedef struct {
    logic [W-1:0] code;
    logic [W-1:0] guess;
    int           red;
    int           white;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pk(input int p0, input int p1, input int p2, input int p3);
    return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  // Standard Mastermind scoring: total colour overlap minus exact hits.
  function automatic void model(input logic [W-1:0] c, input logic [W-1:0] g,
                                output int r, output int w);
    int cc [8];
    int gc [8];
    int total;
    for (int k = 0; k < 8; k++) begin
      cc[k] = 0;
      gc[k] = 0;
    end
    r = 0;
    total = 0;
    for (int i = 0; i < PEGS; i++) begin
      if (c[i*COLOR_W +: COLOR_W] == g[i*COLOR_W +: COLOR_W]) r++;
      cc[c[i*COLOR_W +: COLOR_W]]++;
      gc[g[i*COLOR_W +: COLOR_W]]++;
    end
    for (int k = 0; k < 8; k++) total += (cc[k] < gc[k]) ? cc[k] : gc[k];
    w = total - r;
  endfunction

  function automatic int exp_lat(input int r);
`ifdef PEG_SCORER_WIN_EN
    return (r == PEGS) ? PEGS + 1 : 2 * PEGS + 1;
`else
    return 2 * PEGS + 1;
`endif
  endfunction

  // One scoring; cycle 0 is the cycle in which start is sampled. Inputs are
  // scrambled while busy to confirm the latched values are used.
  task automatic run_one(input string name, input logic [W-1:0] c, input logic [W-1:0] g,
                         input int er, input int ew);
    int n;
    int lat;
    @(negedge clock);
    code  = c;
    guess = g;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 1;
    chk({name, " busy"}, busy, 1);
    chk({name, " white cleared"}, white, 0);
    lat = -1;
    while (n < 40 && lat < 0) begin
      if (done) begin
        lat = n;
      end else begin
        code  = W'($urandom);
        guess = W'($urandom);
        @(negedge clock);
        n++;
      end
    end
    chk({name, " latency"}, lat, exp_lat(er));
    chk({name, " red"}, red, er);
    chk({name, " white"}, white, ew);
`ifdef PEG_SCORER_WIN_EN
    chk({name, " win"}, win, (er == PEGS) ? 1 : 0);
`endif
    @(negedge clock);
    chk({name, " done pulse"}, done, 0);
    chk({name, " idle"}, busy, 0);
    chk({name, " red hold"}, red, er);
    chk({name, " white hold"}, white, ew);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int   r;
    int   w;
    int   pulses;
    logic [W-1:0] rc;
    logic [W-1:0] rg;

    vecs[0] = '{pk(1, 2, 3, 4), pk(1, 2, 3, 4), 4, 0};
    vecs[1] = '{pk(1, 2, 3, 4), pk(4, 3, 2, 1), 0, 4};
    vecs[2] = '{pk(1, 1, 2, 2), pk(1, 2, 1, 1), 1, 2};
    vecs[3] = '{pk(5, 5, 5, 5), pk(5, 0, 0, 0), 1, 0};
    vecs[4] = '{pk(0, 0, 0, 7), pk(7, 7, 7, 7), 1, 0};
    vecs[5] = '{pk(0, 0, 0, 0), pk(1, 1, 1, 1), 0, 0};

    // Reset state
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset red", red, 0);
    chk("reset white", white, 0);
`ifdef PEG_SCORER_WIN_EN
    chk("reset win", win, 0);
`endif

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].code, vecs[i].guess, vecs[i].red, vecs[i].white);
    end

    // Random guesses from a small palette so duplicates are common
    for (int i = 0; i < 40; i++) begin
      rc = '0;
      rg = '0;
      for (int p = 0; p < PEGS; p++) begin
        rc[p*COLOR_W +: COLOR_W] = 3'($urandom_range(0, 3));
        rg[p*COLOR_W +: COLOR_W] = 3'($urandom_range(0, 3));
      end
      if (i % 8 == 0) rg = rc;
      model(rc, rg, r, w);
      run_one($sformatf("rnd%0d", i), rc, rg, r, w);
    end

    // Reset pulled low during WHITE aborts scoring with no done pulse
    @(negedge clock);
    code  = pk(1, 2, 3, 4);
    guess = pk(1, 2, 4, 3);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    chk("abort red before reset", red, 2);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    chk("abort busy", busy, 0);
    chk("abort red", red, 0);
    chk("abort white", white, 0);
    chk("abort done", done, 0);
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clock);
      if (done) pulses++;
    end
    chk("abort no done", pulses, 0);

    // start pulsed during RED is ignored; done pulses once
    @(negedge clock);
    code  = pk(1, 1, 2, 2);
    guess = pk(1, 2, 1, 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    pulses = 0;
    for (int n = 0; n < 25; n++) begin
      if (done) pulses++;
      @(negedge clock);
    end
    chk("ignored start done count", pulses, 1);
    chk("ignored start red", red, 1);
    chk("ignored start white", white, 2);

    // start held high: next scoring accepted in the IDLE cycle after done
    @(negedge clock);
    code  = pk(1, 2, 3, 4);
    guess = pk(4, 3, 2, 1);
    start = 1'b1;
    repeat (9) @(negedge clock);
    chk("held first done", done, 1);
    chk("held first white", white, 4);
    @(negedge clock);
    chk("held idle busy", busy, 0);
    chk("held idle white", white, 4);
    @(negedge clock);
    chk("held reaccept busy", busy, 1);
    chk("held reaccept white", white, 0);
    repeat (7) @(negedge clock);
    chk("held second not early", done, 0);
    @(negedge clock);
    chk("held second done", done, 1);
    chk("held second white", white, 4);
    start = 1'b0;
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
